reg_dump_reader: RTL and testbench

Debug reader for the integer register file. On a `start` pulse it walks a configurable window of architectural registers through one register-file read port and streams each 64-bit value out over a valid/ready channel. It sits beside the core, sharing the register file's second read port with the debug path, and feeds the cosim/trace link or a UART serializer. It is the read-side counterpart to the register-file write path. It never writes registers.

---
 rtl/reg_dump_reader_pkg.sv | 15 +
 rtl/reg_dump_reader.sv | 133 +++++++++++++
 tb/tb_reg_dump_reader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_reader_pkg.sv
// Shared types and constants for the register-file dump reader.
package RegDumpPkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        CSUM
    } dump_state_t;

    localparam int REG_NUM = 32;
    localparam int REG_W   = 64;
    localparam int IDX_W   = 5;

endpackage

// File: rtl/reg_dump_reader.sv
// Streams registers FIRST_REG..LAST_REG from a register-file read port over valid/ready.
// Build option REG_DUMP_CHECKSUM_EN appends an XOR checksum beat after the last register.
//
// state | meaning
// IDLE  | waiting for start; busy low
// READ  | read_addr = idx, payload captured at the edge
// SEND  | register beat offered until accepted
// CSUM  | checksum beat offered (checksum build only)
module reg_dump_reader
    import RegDumpPkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    output logic [IDX_W-1:0] read_addr,
    input  logic [REG_W-1:0] read_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REG_W-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > REG_NUM - 1) begin : g_param_check
        $error("reg_dump_reader: window must satisfy 0 <= FIRST_REG <= LAST_REG <= 31");
    end

    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

    dump_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [REG_W-1:0] data_q,  data_d;
    logic             done_q,  done_d;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [REG_W-1:0] acc_q,   acc_d;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            done_q  <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        done_d    = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
        acc_d     = acc_q;
`endif
        out_valid = 1'b0;
        out_data  = data_q;
        out_idx   = idx_q;
        out_last  = 1'b0;
        read_addr = idx_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = FIRST_IDX;
`ifdef REG_DUMP_CHECKSUM_EN
                    acc_d   = '0;
`endif
                    state_d = READ;
                end
            end
            READ: begin
                data_d  = read_data;
                state_d = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
`ifndef REG_DUMP_CHECKSUM_EN
                out_last  = (idx_q == LAST_IDX);
`endif
                if (out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    acc_d = acc_q ^ data_q;
`endif
                    if (idx_q == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = READ;
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
                out_valid = 1'b1;
                out_data  = acc_q;
                out_idx   = '0;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: scoreboard of expected beats, register-file model.
module tb_reg_dump_reader;

    typedef struct {
        logic [4:0]  idx;
        logic [63:0] data;
        logic        last;
    } beat_t;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int CSUM_EN = 1;
`else
    localparam int CSUM_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [4:0]  read_addr;
    logic [63:0] read_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    logic        start5;
    logic [4:0]  read_addr5;
    logic [63:0] read_data5;
    logic        out_valid5;
    logic [63:0] out_data5;
    logic [4:0]  out_idx5;
    logic        out_last5;
    logic        busy5;
    logic        done5;

    logic [63:0] rf [32];

    beat_t sb[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    int    beats    = 0;
    bit    mon_en   = 1'b0;
    bit    stall_pend = 1'b0;
    logic [63:0] stall_data;
    logic [4:0]  stall_idx;
    logic        stall_last;

    always #5 clk = ~clk;

    assign read_data  = (read_addr  == 5'd0) ? 64'd0 : rf[read_addr];
    assign read_data5 = (read_addr5 == 5'd0) ? 64'd0 : rf[read_addr5];

    reg_dump_reader dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .read_addr (read_addr),
        .read_data (read_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    reg_dump_reader #(.FIRST_REG(5), .LAST_REG(5)) dut5 (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start5),
        .read_addr (read_addr5),
        .read_data (read_data5),
        .out_valid (out_valid5),
        .out_ready (1'b1),
        .out_data  (out_data5),
        .out_idx   (out_idx5),
        .out_last  (out_last5),
        .busy      (busy5),
        .done      (done5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected stream for the default window; wr_idx >= 0 overrides one value.
    task automatic push_dump(input int wr_idx, input logic [63:0] wr_val);
        beat_t b;
        logic [63:0] x;
        x = 64'd0;
        for (int i = 0; i < 32; i++) begin
            b.idx  = 5'(i);
            b.data = (i == 0) ? 64'd0 : ((i == wr_idx) ? wr_val : rf[i]);
            b.last = (CSUM_EN == 0) && (i == 31);
            x      = x ^ b.data;
            sb.push_back(b);
        end
        if (CSUM_EN != 0) begin
            b.idx  = 5'd0;
            b.data = x;
            b.last = 1'b1;
            sb.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_pend) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data",  out_data,  stall_data);
                chk("stall_idx",   out_idx,   stall_idx);
                chk("stall_last",  out_last,  stall_last);
            end
            if (out_valid && out_ready) begin
                chk("beat_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("beat_idx",  out_idx,  e.idx);
                    chk("beat_data", out_data, e.data);
                    chk("beat_last", out_last, e.last);
                end
                beats++;
            end
            stall_pend = out_valid && !out_ready;
            stall_data = out_data;
            stall_idx  = out_idx;
            stall_last = out_last;
        end else begin
            stall_pend = 1'b0;
        end
    end

    task automatic run_dump(input bit toggle, input bit start2, input bit wr, input bit rst,
                            output int got_done);
        bit fired;
        fired    = 1'b0;
        got_done = -1;
        beats    = 0;
        push_dump(wr ? 20 : -1, 64'hABCD);
        mon_en   = 1'b1;
        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (done) begin
                got_done = k;
                chk("busy_in_done_cycle", busy, 1'b0);
                break;
            end
            if (rst && !fired && beats == 12 && out_valid) begin
                mon_en = 1'b0;
                rstn   = 1'b0;
                #1;
                chk("rst_valid", out_valid, 1'b0);
                chk("rst_busy",  busy,      1'b0);
                chk("rst_last",  out_last,  1'b0);
                for (int j = 0; j < 3; j++) begin
                    @(posedge clk); #1;
                    chk("rst_no_done", done, 1'b0);
                end
                rstn = 1'b1;
                sb.delete();
                return;
            end
            start = 1'b0;
            if (start2 && !fired && beats == 10) begin
                start = 1'b1;
                fired = 1'b1;
            end
            if (wr && !fired && out_valid && out_idx == 5'd15) begin
                rf[20] = 64'hABCD;
                fired  = 1'b1;
            end
            out_ready = toggle ? ((k % 4 == 1) || (k % 4 == 0)) : 1'b1;
            @(posedge clk); #1;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        chk("idle_after", busy, 1'b0);
        mon_en = 1'b0;
    endtask

    initial begin
        int d;
        int exp_done;
        exp_done  = 65 + CSUM_EN;
        rstn      = 1'b0;
        start     = 1'b0;
        start5    = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 64'(i) * 64'h1111;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data",  out_data,  64'd0);
        chk("rst_out_idx",   out_idx,   5'd0);
        chk("rst_out_last",  out_last,  1'b0);
        chk("rst_busy0",     busy,      1'b0);
        chk("rst_done",      done,      1'b0);
        chk("rst_read_addr", read_addr, 5'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        run_dump(1'b0, 1'b0, 1'b0, 1'b0, d);
        chk("done_cycle_plain", d, exp_done);

        run_dump(1'b1, 1'b0, 1'b0, 1'b0, d);
        chk("done_seen_toggle", d > 0, 1'b1);

        run_dump(1'b0, 1'b1, 1'b0, 1'b0, d);
        chk("done_cycle_start2", d, exp_done);

        run_dump(1'b0, 1'b0, 1'b1, 1'b0, d);
        chk("done_cycle_write", d, exp_done);

        run_dump(1'b0, 1'b0, 1'b0, 1'b1, d);
        run_dump(1'b0, 1'b0, 1'b0, 1'b0, d);
        chk("done_cycle_restart", d, exp_done);

        rf[5] = 64'hDEADBEEF;
        @(posedge clk); #1;
        start5 = 1'b1;
        @(posedge clk); #1;
        start5 = 1'b0;
        chk("w5_read_valid", out_valid5, 1'b0);
        @(posedge clk); #1;
        chk("w5_valid", out_valid5, 1'b1);
        chk("w5_idx",   out_idx5,   5'd5);
        chk("w5_data",  out_data5,  64'hDEADBEEF);
        chk("w5_last",  out_last5,  (CSUM_EN == 0) ? 1'b1 : 1'b0);
        if (CSUM_EN != 0) begin
            @(posedge clk); #1;
            chk("w5_csum_valid", out_valid5, 1'b1);
            chk("w5_csum_idx",   out_idx5,   5'd0);
            chk("w5_csum_data",  out_data5,  64'hDEADBEEF);
            chk("w5_csum_last",  out_last5,  1'b1);
        end
        @(posedge clk); #1;
        chk("w5_done", done5, 1'b1);
        chk("w5_busy", busy5, 1'b0);
        @(posedge clk); #1;
        chk("w5_done_pulse", done5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
